// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, bit indices and FSM states for the MMIO UART transmitter
package uart_pkg;

    localparam logic [63:0] REG_DATA   = 64'h00;
    localparam logic [63:0] REG_STATUS = 64'h08;
    localparam logic [63:0] REG_CTRL   = 64'h10;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_CLR_OVF = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - byte-wide synchronous FIFO; pushes while full and pops while empty are ignored
module sync_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic [7:0]  pop_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO, status/control and drain interrupt
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] bus_address,
    input  logic [63:0] bus_write_data,
    input  logic        bus_write_enable,
    input  logic        bus_read_enable,
    output logic [63:0] bus_read_data,
    output logic        uart_txd,
    output logic        irq
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int NW  = $clog2(FIFO_DEPTH) + 1;

    logic          sel_data;
    logic          sel_status;
    logic          sel_ctrl;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [NW-1:0] fifo_count;
    logic          irq_en;
    logic          overflow;
    logic [63:0]   read_mux;
    tx_state_t     state;
    logic [CW-1:0] baud_cnt;
    logic          baud_last;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          unused_wdata;

    assign sel_data   = (bus_address == BASE_ADDR + REG_DATA);
    assign sel_status = (bus_address == BASE_ADDR + REG_STATUS);
    assign sel_ctrl   = (bus_address == BASE_ADDR + REG_CTRL);

    assign fifo_push    = bus_write_enable && sel_data;
    assign fifo_pop     = (state == S_IDLE) && !fifo_empty;
    assign baud_last    = (baud_cnt == CW'(DIV - 1));
    assign unused_wdata = ^bus_write_data[63:8];

    sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus_write_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        read_mux = '0;
        if (sel_status) begin
            read_mux[ST_BUSY]              = (state != S_IDLE);
            read_mux[ST_FULL]              = fifo_full;
            read_mux[ST_EMPTY]             = fifo_empty;
            read_mux[ST_OVERFLOW]          = overflow;
            read_mux[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
        end else if (sel_ctrl) begin
            read_mux[CTRL_IRQ_EN]          = irq_en;
        end
    end

    // A dropped push sets overflow even if a clear lands in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en        <= 1'b0;
            overflow      <= 1'b0;
            bus_read_data <= '0;
            irq           <= 1'b0;
        end else begin
            if (bus_write_enable && sel_ctrl) begin
                irq_en <= bus_write_data[CTRL_IRQ_EN];
            end
            if (fifo_push && fifo_full) begin
                overflow <= 1'b1;
            end else if (bus_write_enable && sel_ctrl && bus_write_data[CTRL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
            if (bus_read_enable) begin
                bus_read_data <= read_mux;
            end
            irq <= irq_en && fifo_empty && (state == S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            uart_txd <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shreg    <= fifo_dout;
                        uart_txd <= 1'b0;
                        baud_cnt <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_txd <= shreg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_txd <= 1'b1;
                            state    <= S_STOP;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            shreg    <= {1'b0, shreg[7:1]};
                            uart_txd <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench for uart_tx_mmio with a cycle-arithmetic reference model
module tb_uart_tx_mmio;

    localparam int          DIV   = 10;
    localparam int          DEPTH = 16;
    localparam int          FRAME = 10 * DIV;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] bus_address = '0;
    logic [63:0] bus_write_data = '0;
    logic        bus_write_enable = 1'b0;
    logic        bus_read_enable = 1'b0;
    logic [63:0] bus_read_data;
    logic        uart_txd;
    logic        irq;

    uart_tx_mmio #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_write_enable (bus_write_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .uart_txd         (uart_txd),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_miss = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // Each accepted byte: edge it was pushed, edge its start bit begins, payload.
    typedef struct {
        int         push;
        int         start;
        logic [7:0] data;
    } rec_t;

    typedef struct {
        int          at;
        logic [63:0] addr;
        logic [63:0] val;
    } rd_t;

    rec_t recs[$];
    rec_t frame_q[$];
    rd_t  rd_q[$];
    int   last_start = -1000;
    int   last_reset_edge = 0;
    bit   en_val = 0, en_prev = 0;
    int   en_edge = 0;
    bit   ov_val = 0, ov_prev = 0;
    int   ov_edge = 0;

    function automatic int count_at(input int e);
        int c = 0;
        foreach (recs[i]) if (recs[i].push < e && recs[i].start >= e) c++;
        return c;
    endfunction

    function automatic bit busy_at(input int e);
        foreach (recs[i]) if (recs[i].start < e && e <= recs[i].start + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit en_at(input int e);
        return (e > en_edge) ? en_val : en_prev;
    endfunction

    function automatic bit ov_at(input int e);
        return (e > ov_edge) ? ov_val : ov_prev;
    endfunction

    function automatic bit irq_at(input int e);
        if (e <= last_reset_edge) return 1'b0;
        return en_at(e) && (count_at(e) == 0) && !busy_at(e);
    endfunction

    function automatic logic [63:0] status_at(input int e);
        logic [63:0] s = '0;
        int c = count_at(e);
        s[0]    = busy_at(e);
        s[1]    = (c == DEPTH);
        s[2]    = (c == 0);
        s[3]    = ov_at(e);
        s[15:8] = 8'(c);
        return s;
    endfunction

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        int e = cyc + 1;
        bus_address      = a;
        bus_write_data   = d;
        bus_write_enable = 1'b1;
        if (a == BASE) begin
            if (count_at(e) < DEPTH) begin
                rec_t r;
                r.push  = e;
                r.start = (e + 1 > last_start + FRAME + 1) ? e + 1 : last_start + FRAME + 1;
                r.data  = d[7:0];
                last_start = r.start;
                recs.push_back(r);
                frame_q.push_back(r);
            end else begin
                ov_prev = ov_at(e); ov_val = 1'b1; ov_edge = e;
            end
        end else if (a == BASE + 64'h10) begin
            en_prev = en_at(e); en_val = d[0]; en_edge = e;
            if (d[1]) begin
                ov_prev = ov_at(e); ov_val = 1'b0; ov_edge = e;
            end
        end
        @(posedge clk); #1;
        bus_write_enable = 1'b0;
    endtask

    task automatic rd(input logic [63:0] a);
        rd_t r;
        r.at   = cyc + 1;
        r.addr = a;
        if (a == BASE + 64'h08)      r.val = status_at(r.at);
        else if (a == BASE + 64'h10) r.val = {63'b0, en_at(r.at)};
        else                         r.val = '0;
        rd_q.push_back(r);
        bus_address     = a;
        bus_read_enable = 1'b1;
        @(posedge clk); #1;
        bus_read_enable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        recs.delete();
        frame_q.delete();
        last_start = -1000;
        en_val = 0; en_prev = 0; ov_val = 0; ov_prev = 0;
        @(posedge clk); #1;
        chk("txd_after_reset", {63'b0, uart_txd}, 64'd1);
        chk("rdata_after_reset", bus_read_data, 64'd0);
        chk("irq_after_reset", {63'b0, irq}, 64'd0);
        @(posedge clk); #1;
        last_reset_edge = cyc;
        en_edge = cyc; ov_edge = cyc;
        reset = 1'b0;
    endtask

    // Line monitor: decodes every frame and checks its start edge, shape and payload.
    int         mon_pos = -1;
    bit         mon_skip = 0;
    int         mon_bad = 0;
    rec_t       cur;
    logic [7:0] dec;

    always @(negedge clk) begin
        if (reset) begin
            mon_pos = -1;
        end else begin
            if (mon_pos < 0 && uart_txd !== 1'b1) begin
                mon_pos = 0; mon_bad = 0; dec = '0;
                if (frame_q.size() == 0) begin
                    mon_skip = 1;
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_frame @cycle %0d: txd=%b, expected idle 1", cyc, uart_txd);
                end else begin
                    mon_skip = 0;
                    cur = frame_q.pop_front();
                    chk("frame_start_cycle", 64'(cyc), 64'(cur.start));
                end
            end
            if (mon_pos >= 0) begin
                logic expb;
                if (mon_pos < DIV)          expb = 1'b0;
                else if (mon_pos < 9 * DIV) expb = cur.data[(mon_pos - DIV) / DIV];
                else                        expb = 1'b1;
                if (mon_pos >= DIV && mon_pos < 9 * DIV && (mon_pos - DIV) % DIV == DIV / 2)
                    dec[(mon_pos - DIV) / DIV] = uart_txd;
                if (!mon_skip && uart_txd !== expb) mon_bad++;
                mon_pos++;
                if (mon_pos == FRAME) begin
                    if (!mon_skip) begin
                        chk("frame_data", {56'b0, dec}, {56'b0, cur.data});
                        chk("frame_bad_cycles", 64'(mon_bad), 64'd0);
                    end
                    mon_pos = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) chk("irq", {63'b0, irq}, {63'b0, irq_at(cyc)});
    end

    always @(negedge clk) begin
        if (rd_q.size() != 0 && rd_q[0].at == cyc) begin
            rd_t r;
            r = rd_q.pop_front();
            chk($sformatf("read_%0h", r.addr), bus_read_data, r.val);
        end
    end

    task automatic wait_drain();
        int t = 0;
        while ((frame_q.size() != 0 || mon_pos >= 0) && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 5000) begin
            n_vec++; n_miss++;
            $display("FAIL drain_timeout: %0d frames pending, expected 0", frame_q.size());
        end
    endtask

    initial begin
        do_reset();
        rd(BASE + 64'h08);
        rd(BASE + 64'h10);

        wr(BASE, 64'h41);
        idle(100);
        rd(BASE + 64'h08);

        for (int i = 0; i < 18; i++) wr(BASE, 64'($urandom_range(0, 255)));
        rd(BASE + 64'h08);
        idle(150);
        rd(BASE + 64'h08);
        wr(BASE + 64'h10, 64'h2);
        rd(BASE + 64'h08);
        wait_drain();
        idle(3);

        wr(BASE + 64'h10, 64'h1);
        idle(3);
        rd(BASE + 64'h10);
        wr(BASE, 64'($urandom_range(0, 255)));
        wait_drain();
        idle(5);

        for (int i = 0; i < 4; i++) wr(BASE, 64'($urandom_range(0, 255)));
        idle(30);
        do_reset();
        rd(BASE + 64'h08);
        rd(BASE + 64'h10);
        idle(300);

        wr(BASE + 64'h18, 64'h55);
        wr(BASE + 64'h100, 64'haa);
        rd(BASE + 64'h18);
        rd(BASE + 64'h100);
        rd(BASE);
        rd(BASE + 64'h08);
        idle(50);

        for (int i = 0; i < 300; i++) begin
            int op = int'($urandom_range(0, 9));
            if (op <= 4)      wr(BASE, 64'($urandom));
            else if (op == 5) idle(int'($urandom_range(1, 30)));
            else if (op <= 7) rd(BASE + 64'h08);
            else if (op == 8) wr(BASE + 64'h10, 64'($urandom_range(0, 3)));
            else              rd(BASE + 64'($urandom_range(0, 5) * 8));
        end
        wait_drain();
        rd(BASE + 64'h08);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the riscv64 core's data bus at base 0x8000_0000.
- Core stores bytes to the DATA register; they queue in a byte FIFO and are serialized 8N1 on `uart_txd`.
- Status and control registers are readable over the same bus.
- A level interrupt output feeds the core's `interrupt_vector` to signal "transmitter drained".

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters:
- CLK_HZ, 50_000_000, core clock frequency.
- BAUD, 115200, line rate; DIV = CLK_HZ/BAUD (integer division, ≥2).
- FIFO_DEPTH, 16, TX FIFO entries; power of two, ≥2.
- BASE_ADDR, 64'h8000_0000, register block base.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- bus_address  in  64  byte address from core
- bus_write_data  in  64  write data; only [7:0] / [1:0] used
- bus_write_enable  in  1  one-cycle write strobe
- bus_read_enable  in  1  one-cycle read strobe
- bus_read_data  out  64  registered read data
- uart_txd  out  1  serial line, idle high
- irq  out  1  level interrupt

## Operation
Register map (offsets from BASE_ADDR):
- 0x00 DATA, write-only.
  - Write pushes bus_write_data[7:0] into the FIFO.
  - Reads return 0.
- 0x08 STATUS, read-only.
  - bit0 busy: FSM not IDLE.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow (sticky).
  - [15:8] FIFO count.
  - Writes are ignored.
- 0x10 CTRL.
  - bit0 irq_en (read/write).
  - Writing bit1=1 clears overflow; bit1 reads 0.

Address decode and read data:
- Any other address inside or outside the block: writes ignored, reads return 0.
- Read and write strobes in the same cycle: both are serviced.

FIFO push rules:
- Fullness is sampled at the start of the cycle.
- A push while full is dropped and sets overflow, even if a pop occurs that same cycle.

Transmit FSM, states IDLE, START, DATA, STOP:
- IDLE
  - If the FIFO is non-empty: pop, load the shift register, go to START.
  - Otherwise stay in IDLE.
- START: txd=0 for DIV cycles, then DATA.
- DATA: 8 bits LSB first, DIV cycles each. A 3-bit counter reaching 7 goes to STOP.
- STOP: txd=1 for DIV cycles, then IDLE.
- The baud counter runs 0..DIV-1 and restarts on every state entry.

Interrupt:
- irq is registered: irq <= irq_en & empty & (state==IDLE).

## Timing
Reset values:
- uart_txd=1, irq=0, bus_read_data=0.
- FIFO empty, state IDLE.
- irq_en=0, overflow=0.

Latencies:
- Write accepted at edge E0 → FIFO count updates at E0.
- IDLE pops at E1 and uart_txd falls at E1 (1 cycle after the push edge when idle).
- Frame length is 10·DIV cycles.
- Back-to-back frames insert exactly one IDLE cycle, so the stop bit lasts DIV+1 cycles.
- Read: strobe sampled at edge R → bus_read_data valid after R and held until the next read.
- irq responds one cycle after the underlying condition changes.

Reset mid-frame:
- Frame aborted; uart_txd=1 at the next edge.
- FIFO flushed; CTRL and overflow cleared.

Bounds:
- FIFO pointers wrap modulo FIFO_DEPTH.
- The count is log2(FIFO_DEPTH)+1 bits wide, zero-extended into [15:8].

## Structure
- Package `uart_pkg` holds:
  - register offsets (DATA/STATUS/CTRL);
  - STATUS/CTRL bit indices;
  - the FSM state enum.
- Sub-module `sync_fifo`: 8-bit wide, parameterised depth, synchronous reset, with push, pop, full, empty and count.
- The top level holds the decode, registers, baud counter and FSM.

## Test plan
The bench runs with CLK_HZ=1_000_000, BAUD=100_000 (DIV=10), FIFO_DEPTH=16.

1. Reset, then write 0x41 to 0x8000_0000.
   - txd falls one edge later and holds 0 for 10 cycles.
   - It then shows 1,0,0,0,0,0,1,0 for 10 cycles each, then 1.
   - After 100 cycles, STATUS busy=0 and empty=1.
2. Write 18 bytes on consecutive cycles.
   - The 18th is dropped; STATUS reads overflow=1, count=16.
   - Exactly 17 frames are emitted.
   - Writing CTRL=0x2 clears overflow.
3. Read 0x8000_0008 mid-frame.
   - The next cycle bus_read_data shows bit0=1 and the count matches the bytes queued.
4. Write CTRL=0x1 while idle and empty → irq=1 one cycle later.
   - Write DATA → irq=0 within 2 cycles.
   - irq returns to 1 one cycle after the final stop bit ends.
5. Assert reset during the DATA state with 3 bytes queued.
   - txd=1 at the next edge; STATUS then reads empty=1, busy=0.
   - No further frame is emitted.
6. Write to 0x8000_0018 and 0x8000_0100 → no FIFO push; reading either returns 0.
